// File: rtl/fir4_pkg.sv
// Shared constants and sample/sum types for the 4-tap unity FIR.
// Sums carry two guard bits so four full-scale taps never overflow.
package fir4_pkg;
  localparam int W   = 16;
  localparam int BLK = 4;

  typedef logic signed [W-1:0] sample_t;
  typedef logic signed [W+1:0] sum_t;
endpackage

// File: rtl/fir4_carry_select_adder_u_csel.sv
// N-bit carry-select adder built from BLK-bit ripple blocks.
// Final carry-out is dropped: result is sum mod 2^N.
module csel_adder #(
  parameter int N   = 17,
  parameter int BLK = fir4_pkg::BLK
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic        [N-1:0] sum
);
  import fir4_pkg::*;

  localparam int NB = (N + BLK - 1) / BLK;
  localparam int NC = (NB > 1) ? NB - 1 : 1;

  // cb[i] is the resolved carry out of block i
  logic [NC-1:0] cb;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int LO = i * BLK;
    localparam int BW = (N - LO < BLK) ? N - LO : BLK;
    localparam int CW = (i == NB - 1) ? BW - 1 : BW;

    logic [CW:0]   c0;
    logic [BW-1:0] s0;

    assign c0[0] = 1'b0;
    for (genvar j = 0; j < BW; j++) begin : g_r0
      assign s0[j] = a[LO+j] ^ b[LO+j] ^ c0[j];
      if (j < CW) begin : g_c
        assign c0[j+1] = (a[LO+j] & b[LO+j]) |
                         (a[LO+j] & c0[j]) |
                         (b[LO+j] & c0[j]);
      end
    end

    if (i == 0) begin : g_lsb
      assign sum[LO +: BW] = s0;
      if (NB > 1) begin : g_co
        assign cb[0] = c0[BW];
      end
    end else begin : g_sel
      logic [CW:0]   c1;
      logic [BW-1:0] s1;

      assign c1[0] = 1'b1;
      for (genvar j = 0; j < BW; j++) begin : g_r1
        assign s1[j] = a[LO+j] ^ b[LO+j] ^ c1[j];
        if (j < CW) begin : g_c
          assign c1[j+1] = (a[LO+j] & b[LO+j]) |
                           (a[LO+j] & c1[j]) |
                           (b[LO+j] & c1[j]);
        end
      end

      assign sum[LO +: BW] = cb[i-1] ? s1 : s0;
      if (i < NB - 1) begin : g_co
        assign cb[i] = cb[i-1] ? c1[BW] : c0[BW];
      end
    end
  end
endmodule

// File: rtl/fir4_carry_select_adder_u.sv
// 4-tap unity-coefficient signed FIR: s = sum of last four samples.
// Balanced two-level carry-select tree between tap and output flops.
module fir4_carry_select_adder_u #(
  parameter int w   = fir4_pkg::W,
  parameter int BLK = fir4_pkg::BLK
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [w-1:0] a,
  output logic [w+1:0] s
);
  import fir4_pkg::*;

  logic [w-1:0] ar_q, br_q, cr_q, dr_q;
  logic [w-1:0] ar_d, br_d, cr_d, dr_d;
  logic [w+1:0] s_q, s_d;
  logic [w:0]   p, q;
  logic [w+1:0] t;

  csel_adder #(.N(w+1), .BLK(BLK)) u_add_p (
    .a   ({ar_q[w-1], ar_q}),
    .b   ({br_q[w-1], br_q}),
    .sum (p)
  );

  csel_adder #(.N(w+1), .BLK(BLK)) u_add_q (
    .a   ({cr_q[w-1], cr_q}),
    .b   ({dr_q[w-1], dr_q}),
    .sum (q)
  );

  csel_adder #(.N(w+2), .BLK(BLK)) u_add_t (
    .a   ({p[w], p}),
    .b   ({q[w], q}),
    .sum (t)
  );

  always_comb begin
    ar_d = a;
    br_d = ar_q;
    cr_d = br_q;
    dr_d = cr_q;
    s_d  = t;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ar_q <= '0;
      br_q <= '0;
      cr_q <= '0;
      dr_q <= '0;
      s_q  <= '0;
    end else begin
      ar_q <= ar_d;
      br_q <= br_d;
      cr_q <= cr_d;
      dr_q <= dr_d;
      s_q  <= s_d;
    end
  end

  assign s = s_q;
endmodule

// File: tb/tb_fir4_carry_select_adder_u.sv
// Scoreboard bench: stimulus pushes the expected sum, monitor pops
// and compares after every rising edge.
module tb_fir4_carry_select_adder_u;
  import fir4_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] a;
  logic [17:0] s;

  int passed;
  int total;
  int hist[4];
  logic [17:0] expq[$];

  fir4_carry_select_adder_u dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .s     (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [17:0] got,
                     input logic [17:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // one sample per cycle; model = plain sum of the last four captures
  task automatic drive(input logic [15:0] v, input logic rst);
    int e;
    sample_t sv;
    @(negedge clk);
    a = v;
    reset = rst;
    if (!rst) begin
      for (int i = 0; i < 4; i++) hist[i] = 0;
      e = 0;
    end else begin
      e = hist[0] + hist[1] + hist[2] + hist[3];
      sv = v;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = int'(sv);
    end
    expq.push_back(18'(e));
  endtask

  task automatic chk_now(input string nm, input logic [17:0] exp);
    @(posedge clk);
    #1;
    chk(nm, s, exp);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) chk("stream", s, expq.pop_front());
    end
  end

  initial begin
    sum_t r;
    passed = 0;
    total = 0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    reset = 1'b0;
    a = '0;
    #1;
    chk("reset_init", s, 18'h0);

    for (int i = 0; i < 6; i++) drive(16'($urandom), 1'b0);

    drive(16'h0001, 1'b1);
    for (int i = 0; i < 6; i++) drive(16'h0000, 1'b1);

    for (int i = 0; i < 4; i++) drive(16'h7FFF, 1'b1);
    drive(16'h7FFF, 1'b1);
    chk_now("pos_full", 18'h1FFFC);

    for (int i = 0; i < 4; i++) drive(16'h8000, 1'b1);
    drive(16'h8000, 1'b1);
    chk_now("neg_full", 18'h20000);

    for (int i = 0; i < 2; i++) begin
      drive(16'h7FFF, 1'b1);
      drive(16'h8000, 1'b1);
    end
    drive(16'h7FFF, 1'b1);
    chk_now("alternate", 18'h3FFFE);

    drive(16'h000F, 1'b1);
    drive(16'h0001, 1'b1);
    drive(16'h00FF, 1'b1);
    drive(16'h0F01, 1'b1);
    drive(16'h0000, 1'b1);
    chk_now("csel_mix", 18'h01010);

    for (int i = 0; i < 5; i++) drive(16'hFFFF, 1'b1);
    chk_now("all_ones", 18'h3FFFC);

    for (int i = 0; i < 30; i++) drive(16'($urandom), 1'b1);

    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", s, 18'h0);
    r = s;
    drive(16'h1234, 1'b0);
    drive(16'h4321, 1'b0);
    drive(16'h0005, 1'b1);
    for (int i = 0; i < 25; i++) drive(16'($urandom), 1'b1);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    if (expq.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
